// File: rtl/packet_builder_pkg.sv
// Shared state encoding and header-geometry helpers for packet_builder.
package packet_builder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_TAIL
  } state_e;

  function automatic int hdr_cycs(input int h, input int d);
    return (h + d - 1) / d;
  endfunction

  function automatic int hdr_rem(input int h, input int d);
    return h % d;
  endfunction

  // Number of leading ones in a byte-enable vector, counted from bit d-1 downward.
  function automatic int be_count(input logic [63:0] be, input int d);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 63; i >= 0; i--) begin
      if (i < d) begin
        if (run && be[i]) n++;
        else run = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/packet_builder_merge.sv
// Realigns a payload beat behind R carried-over bytes; R==0 is a plain passthrough.
module packet_builder_merge #(
  parameter int D = 8,
  parameter int R = 2,
  localparam int RW = (R > 0) ? R : 1
) (
  input  logic [8*RW-1:0] residue,
  input  logic [RW-1:0]   residue_be,
  input  logic [8*D-1:0]  in_data,
  input  logic [D-1:0]    in_be,
  output logic [8*D-1:0]  out_data,
  output logic [D-1:0]    out_be,
  output logic [8*RW-1:0] next_residue,
  output logic [RW-1:0]   next_residue_be
);

  if (R > 0) begin : g_merge
    assign out_data        = {residue, in_data[8*D-1 -: 8*(D-R)]};
    assign out_be          = {residue_be, in_be[D-1 -: D-R]};
    assign next_residue    = in_data[8*R-1:0];
    assign next_residue_be = in_be[R-1:0];
  end else begin : g_pass
    assign out_data        = in_data;
    assign out_be          = in_be;
    assign next_residue    = '0;
    assign next_residue_be = '0;
  end

endmodule

// File: rtl/packet_builder.sv
// Prepends headerA/headerB to a payload stream, byte-packed MSB-first.
// Optional protocol checker: define PACKET_BUILDER_PROTO_CHK_EN to add err_proto.
module packet_builder
  import packet_builder_pkg::*;
#(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4
) (
  input  logic                           clk_host,
  input  logic                           rst,
  input  logic                           bus_in_valid,
  output logic                           bus_in_ready,
  input  logic                           bus_in_sop,
  input  logic                           bus_in_eop,
  input  logic [WIDTH_DATA_BYTES-1:0]    bus_in_byteen,
  input  logic [8*WIDTH_DATA_BYTES-1:0]  bus_in_data,
  input  logic [8*WIDTH_HDR_A_BYTES-1:0] headerA,
  input  logic [8*WIDTH_HDR_B_BYTES-1:0] headerB,
  output logic                           bus_out_valid,
  input  logic                           bus_out_ready,
  output logic                           bus_out_sop,
  output logic                           bus_out_eop,
  output logic [WIDTH_DATA_BYTES-1:0]    bus_out_byteen,
  output logic [8*WIDTH_DATA_BYTES-1:0]  bus_out_data,
  output logic [1:0]                     dbg_state
`ifdef PACKET_BUILDER_PROTO_CHK_EN
  ,
  output logic                           err_proto
`endif
);

  localparam int  D          = WIDTH_DATA_BYTES;
  localparam int  DW         = 8 * D;
  localparam int  H          = WIDTH_HDR_A_BYTES + WIDTH_HDR_B_BYTES;
  localparam int  HC         = hdr_cycs(H, D);
  localparam int  R          = hdr_rem(H, D);
  localparam int  RW         = (R > 0) ? R : 1;
  localparam int  SRW        = DW * HC;
  localparam int  PADW       = SRW - 8 * H;
  localparam int  CW         = (HC > 1) ? $clog2(HC) : 1;
  localparam bit  MERGE_IDLE = (HC == 1) && (R > 0);

  // Handshake: a beat moves on a side when valid && ready at the rising clock edge;
  // the output register reloads whenever it is empty or being drained (ld).
  state_e           state_q, state_d, eop_next;
  logic [SRW-1:0]   hdr_pad, hdr_sr, hdr_src;
  logic [CW-1:0]    hdr_cnt, cnt_d;
  logic [8*RW-1:0]  residue, res_src, m_res;
  logic [RW-1:0]    residue_be, res_be_src, m_res_be;
  logic [DW-1:0]    m_data, tail_data, odata_d;
  logic [D-1:0]     m_be, tail_be, obe_d;
  logic             ld, in_ready, hdr_last, hdr_merge, fits, eop_out;
  logic             ovalid_d, osop_d, oeop_d, sr_cap, sr_shift, res_ld;

  assign ld        = !bus_out_valid || bus_out_ready;
  assign hdr_pad   = SRW'({headerA, headerB}) << PADW;
  assign hdr_src   = (state_q == ST_IDLE) ? hdr_pad : hdr_sr;
  assign hdr_last  = (hdr_cnt == CW'(HC - 1));
  assign hdr_merge = ((state_q == ST_IDLE) && MERGE_IDLE) ||
                     ((state_q == ST_HDR) && hdr_last && (R > 0));
  assign res_src    = hdr_merge ? hdr_src[SRW-1 -: 8*RW] : residue;
  assign res_be_src = hdr_merge ? '1 : residue_be;
  assign tail_data  = DW'(residue) << (8 * (D - RW));
  assign tail_be    = D'(residue_be) << (D - RW);
  assign fits       = be_count(64'(bus_in_byteen), D) <= (D - R);
  assign eop_out    = bus_in_eop && fits;
  assign eop_next   = !bus_in_eop ? ST_BODY : (fits ? ST_IDLE : ST_TAIL);
  assign bus_in_ready = in_ready && !rst;
  assign dbg_state    = state_q;

  packet_builder_merge #(.D(D), .R(R)) u_merge (
    .residue         (res_src),
    .residue_be      (res_be_src),
    .in_data         (bus_in_data),
    .in_be           (bus_in_byteen),
    .out_data        (m_data),
    .out_be          (m_be),
    .next_residue    (m_res),
    .next_residue_be (m_res_be)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = hdr_cnt;
    ovalid_d = bus_out_valid;
    osop_d   = bus_out_sop;
    oeop_d   = bus_out_eop;
    obe_d    = bus_out_byteen;
    odata_d  = bus_out_data;
    sr_cap   = 1'b0;
    sr_shift = 1'b0;
    res_ld   = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MERGE_IDLE) in_ready = ld;
        if (ld) begin
          ovalid_d = 1'b0;
          if (bus_in_valid && bus_in_sop) begin
            sr_cap   = 1'b1;
            cnt_d    = CW'(1);
            ovalid_d = 1'b1;
            osop_d   = 1'b1;
            if (MERGE_IDLE) begin
              odata_d = m_data;
              obe_d   = m_be;
              oeop_d  = eop_out;
              res_ld  = 1'b1;
              state_d = eop_next;
            end else begin
              odata_d = hdr_src[SRW-1 -: DW];
              obe_d   = '1;
              oeop_d  = 1'b0;
              state_d = (HC > 1) ? ST_HDR : ST_BODY;
            end
          end
        end
      end
      ST_HDR: begin
        if (hdr_merge) in_ready = ld;
        if (ld) begin
          ovalid_d = 1'b0;
          osop_d   = 1'b0;
          if (!hdr_merge) begin
            ovalid_d = 1'b1;
            oeop_d   = 1'b0;
            odata_d  = hdr_src[SRW-1 -: DW];
            obe_d    = '1;
            sr_shift = 1'b1;
            cnt_d    = hdr_cnt + CW'(1);
            if (hdr_last) state_d = ST_BODY;
          end else if (bus_in_valid) begin
            ovalid_d = 1'b1;
            odata_d  = m_data;
            obe_d    = m_be;
            oeop_d   = eop_out;
            res_ld   = 1'b1;
            state_d  = eop_next;
          end
        end
      end
      ST_BODY: begin
        in_ready = ld;
        if (ld) begin
          ovalid_d = 1'b0;
          if (bus_in_valid) begin
            ovalid_d = 1'b1;
            osop_d   = 1'b0;
            odata_d  = m_data;
            obe_d    = m_be;
            oeop_d   = eop_out;
            res_ld   = 1'b1;
            state_d  = eop_next;
          end
        end
      end
      ST_TAIL: begin
        if (ld) begin
          ovalid_d = 1'b1;
          osop_d   = 1'b0;
          oeop_d   = 1'b1;
          odata_d  = tail_data;
          obe_d    = tail_be;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_host or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk_host or posedge rst) begin
    if (rst) begin
      bus_out_valid  <= 1'b0;
      bus_out_sop    <= 1'b0;
      bus_out_eop    <= 1'b0;
      bus_out_byteen <= '0;
      bus_out_data   <= '0;
      hdr_sr         <= '0;
      hdr_cnt        <= '0;
      residue        <= '0;
      residue_be     <= '0;
    end else begin
      bus_out_valid  <= ovalid_d;
      bus_out_sop    <= osop_d;
      bus_out_eop    <= oeop_d;
      bus_out_byteen <= obe_d;
      bus_out_data   <= odata_d;
      hdr_cnt        <= cnt_d;
      if (sr_cap)        hdr_sr <= hdr_pad << DW;
      else if (sr_shift) hdr_sr <= hdr_sr << DW;
      if (res_ld) begin
        residue    <= m_res;
        residue_be <= m_res_be;
      end
    end
  end

`ifdef PACKET_BUILDER_PROTO_CHK_EN
  logic bad_beat;

  always_comb begin
    bad_beat = 1'b0;
    if ((state_q == ST_BODY) && bus_in_sop) bad_beat = 1'b1;
    if (!bus_in_eop && (bus_in_byteen != '1)) bad_beat = 1'b1;
    if ($countones(bus_in_byteen) != be_count(64'(bus_in_byteen), D)) bad_beat = 1'b1;
    if (bus_in_eop && (bus_in_byteen == '0)) bad_beat = 1'b1;
  end

  always_ff @(posedge clk_host or posedge rst) begin
    if (rst)                                          err_proto <= 1'b0;
    else if (bus_in_valid && bus_in_ready && bad_beat) err_proto <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_packet_builder.sv
// Bench for packet_builder: random packets scored against a byte-stream reference model.
module tb_packet_builder;

  localparam int D  = 8;
  localparam int A  = 6;
  localparam int B  = 4;
  localparam int DW = 8 * D;
  localparam int W  = DW + D + 2;

  logic            clk_host = 1'b0;
  logic            rst;
  logic            bus_in_valid, bus_in_ready, bus_in_sop, bus_in_eop;
  logic [D-1:0]    bus_in_byteen;
  logic [DW-1:0]   bus_in_data;
  logic [8*A-1:0]  headerA;
  logic [8*B-1:0]  headerB;
  logic            bus_out_valid, bus_out_ready, bus_out_sop, bus_out_eop;
  logic [D-1:0]    bus_out_byteen;
  logic [DW-1:0]   bus_out_data;
  logic [1:0]      dbg_state;
`ifdef PACKET_BUILDER_PROTO_CHK_EN
  logic            err_proto;
`endif

  packet_builder #(
    .WIDTH_DATA_BYTES (D),
    .WIDTH_HDR_A_BYTES(A),
    .WIDTH_HDR_B_BYTES(B)
  ) dut (
    .clk_host      (clk_host),
    .rst           (rst),
    .bus_in_valid  (bus_in_valid),
    .bus_in_ready  (bus_in_ready),
    .bus_in_sop    (bus_in_sop),
    .bus_in_eop    (bus_in_eop),
    .bus_in_byteen (bus_in_byteen),
    .bus_in_data   (bus_in_data),
    .headerA       (headerA),
    .headerB       (headerB),
    .bus_out_valid (bus_out_valid),
    .bus_out_ready (bus_out_ready),
    .bus_out_sop   (bus_out_sop),
    .bus_out_eop   (bus_out_eop),
    .bus_out_byteen(bus_out_byteen),
    .bus_out_data  (bus_out_data),
    .dbg_state     (dbg_state)
`ifdef PACKET_BUILDER_PROTO_CHK_EN
    ,
    .err_proto     (err_proto)
`endif
  );

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           out_beats = 0;
  int           sop_cyc_q[$];
  int           eop_cyc_q[$];
  logic [W-1:0] exp_q[$];
  logic [7:0]   pay_q[$];
  bit           mon_en = 1'b1;
  int           rdy_mode = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_out = '0;
  logic [W-1:0] cur_out;

  assign cur_out = {bus_out_sop, bus_out_eop, bus_out_byteen, bus_out_data};

  // ---------------- clock / reset ----------------
  initial forever #5 clk_host = ~clk_host;

  always @(posedge clk_host) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    bus_out_ready = 1'b0;
    forever begin
      @(posedge clk_host);
      #1;
      if (rdy_mode == 0) bus_out_ready = 1'b1;
      else               bus_out_ready = ($urandom_range(0, 99) < 70);
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_packet(input logic [8*A-1:0] ha, input logic [8*B-1:0] hb);
    logic [7:0]    s[$];
    int            nbeats;
    logic [DW-1:0] md;
    logic [D-1:0]  mb;
    for (int i = 0; i < A; i++) s.push_back(ha[8*A-1-8*i -: 8]);
    for (int i = 0; i < B; i++) s.push_back(hb[8*B-1-8*i -: 8]);
    foreach (pay_q[i]) s.push_back(pay_q[i]);
    nbeats = (s.size() + D - 1) / D;
    for (int b = 0; b < nbeats; b++) begin
      md = '0;
      mb = '0;
      for (int k = 0; k < D; k++) begin
        if (b * D + k < s.size()) begin
          md[DW-1-8*k -: 8] = s[b*D+k];
          mb[D-1-k]         = 1'b1;
        end
      end
      exp_q.push_back({b == 0, b == nbeats - 1, mb, md});
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic score_beat();
    logic [W-1:0]  e;
    logic [DW-1:0] m;
    out_beats++;
    if (bus_out_sop) sop_cyc_q.push_back(cyc);
    if (bus_out_eop) eop_cyc_q.push_back(cyc);
    if (exp_q.size() == 0) begin
      check("extra_beat", W'(exp_q.size()), W'(1));
    end else begin
      e = exp_q.pop_front();
      m = '0;
      for (int k = 0; k < D; k++) if (e[DW+k]) m[8*k +: 8] = 8'hff;
      check("sop", W'(bus_out_sop), W'(e[W-1]));
      check("eop", W'(bus_out_eop), W'(e[W-2]));
      check("byteen", W'(bus_out_byteen), W'(e[DW +: D]));
      check("data", W'(bus_out_data & m), W'(e[DW-1:0] & m));
    end
  endtask

  always @(negedge clk_host) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", W'(bus_out_valid), W'(1));
        check("hold_out", cur_out, prev_out);
      end
      if (mon_en && bus_out_valid && bus_out_ready) score_beat();
      stall_prev <= bus_out_valid && !bus_out_ready;
      prev_out   <= cur_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [DW-1:0] data, input logic [D-1:0] be, input logic sop,
                            input logic eop, input logic [8*A-1:0] ha, input logic [8*B-1:0] hb);
    int waited;
    bus_in_valid  = 1'b1;
    bus_in_data   = data;
    bus_in_byteen = be;
    bus_in_sop    = sop;
    bus_in_eop    = eop;
    headerA       = ha;
    headerB       = hb;
    waited        = 0;
    forever begin
      @(negedge clk_host);
      if (bus_in_ready) break;
      waited++;
      if (waited > 100) begin
        check("in_timeout", W'(waited), W'(0));
        break;
      end
    end
    @(posedge clk_host);
    #1;
    bus_in_valid = 1'b0;
    bus_in_sop   = 1'b0;
    bus_in_eop   = 1'b0;
  endtask

  task automatic send_packet(input int nb, input int last_n, input int gap_max, input bit garbage);
    logic [8*A-1:0] ha;
    logic [8*B-1:0] hb;
    logic [DW-1:0]  d;
    logic [D-1:0]   be;
    logic [DW-1:0]  dq[$];
    logic [D-1:0]   bq[$];
    int             n, gap;
    ha = 48'({$urandom(), $urandom()});
    hb = $urandom();
    pay_q.delete();
    for (int i = 0; i < nb; i++) begin
      n  = (i == nb - 1) ? last_n : D;
      d  = {$urandom(), $urandom()};
      be = '0;
      for (int k = 0; k < D; k++) begin
        if (k < n) begin
          be[D-1-k] = 1'b1;
          pay_q.push_back(d[DW-1-8*k -: 8]);
        end else if (!garbage) begin
          d[DW-1-8*k -: 8] = 8'h00;
        end
      end
      dq.push_back(d);
      bq.push_back(be);
    end
    model_packet(ha, hb);
    for (int i = 0; i < nb; i++) begin
      drive_beat(dq[i], bq[i], i == 0, i == nb - 1, ha, hb);
      gap = $urandom_range(0, gap_max);
      if (gap > 0) begin
        repeat (gap) @(posedge clk_host);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk_host);
      t++;
    end
    repeat (3) @(posedge clk_host);
    #1;
    check("drain", W'(exp_q.size()), W'(0));
  endtask

  task automatic directed(input string tag, input int nb, input int last_n, input int beats);
    int b0;
    b0 = out_beats;
    send_packet(nb, last_n, 0, 1'b0);
    wait_drain();
    check(tag, W'(out_beats - b0), W'(beats));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [8*A-1:0] ha;
    logic [8*B-1:0] hb;
    rst           = 1'b1;
    bus_in_valid  = 1'b1;
    bus_in_sop    = 1'b1;
    bus_in_eop    = 1'b0;
    bus_in_byteen = '1;
    bus_in_data   = '0;
    headerA       = '0;
    headerB       = '0;
    #12;
    check("rst_valid", W'(bus_out_valid), W'(0));
    check("rst_out", cur_out, W'(0));
    check("rst_in_ready", W'(bus_in_ready), W'(0));
    bus_in_valid = 1'b0;
    bus_in_sop   = 1'b0;
    @(posedge clk_host);
    #2;
    rst = 1'b0;
    @(posedge clk_host);
    #1;

    directed("beats_4B", 1, 4, 2);
    directed("beats_8B", 1, 8, 3);
    directed("beats_3beat", 3, 5, 4);

    rdy_mode = 1;
    for (int p = 0; p < 40; p++) send_packet($urandom_range(1, 5), $urandom_range(1, 8), 2, 1'b1);
    wait_drain();

    rdy_mode = 0;
    repeat (2) @(posedge clk_host);
    #1;
    sop_cyc_q.delete();
    eop_cyc_q.delete();
    send_packet(1, 8, 0, 1'b1);
    send_packet(2, 3, 0, 1'b1);
    send_packet(1, 2, 0, 1'b1);
    wait_drain();
    if (sop_cyc_q.size() == 3 && eop_cyc_q.size() == 3) begin
      check("b2b_gap1", W'(sop_cyc_q[1] - eop_cyc_q[0]), W'(1));
      check("b2b_gap2", W'(sop_cyc_q[2] - eop_cyc_q[1]), W'(1));
    end else begin
      check("b2b_count", W'(sop_cyc_q.size()), W'(3));
    end

    mon_en = 1'b0;
    ha = 48'({$urandom(), $urandom()});
    hb = $urandom();
    drive_beat({$urandom(), $urandom()}, '1, 1'b1, 1'b0, ha, hb);
    drive_beat({$urandom(), $urandom()}, '1, 1'b0, 1'b0, ha, hb);
    drive_beat({$urandom(), $urandom()}, '1, 1'b0, 1'b0, ha, hb);
    check("pre_arst_valid", W'(bus_out_valid), W'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", W'(bus_out_valid), W'(0));
    check("arst_out", cur_out, W'(0));
    check("arst_in_ready", W'(bus_in_ready), W'(0));
    repeat (2) @(posedge clk_host);
    #2;
    rst = 1'b0;
    @(posedge clk_host);
    #1;
    exp_q.delete();
    mon_en = 1'b1;
    send_packet(2, 6, 1, 1'b1);
    wait_drain();

`ifdef PACKET_BUILDER_PROTO_CHK_EN
    mon_en = 1'b0;
    check("err_clear", W'(err_proto), W'(0));
    drive_beat({$urandom(), $urandom()}, 8'hf0, 1'b1, 1'b0, ha, hb);
    check("err_set", W'(err_proto), W'(1));
    drive_beat({$urandom(), $urandom()}, '1, 1'b0, 1'b1, ha, hb);
    repeat (4) @(posedge clk_host);
    #1;
    check("err_sticky", W'(err_proto), W'(1));
    rst = 1'b1;
    #1;
    check("err_rst", W'(err_proto), W'(0));
    repeat (2) @(posedge clk_host);
    #2;
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
